// File: rtl/sm_serial_multiplier.sv
// sm_serial_multiplier: sequential shift-add sign-magnitude fixed-point multiplier with saturation
module sm_serial_multiplier #(
  parameter int WORD_LENGTH = 16,
  parameter int FRAC_BITS = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [WORD_LENGTH-1:0] A,
  input  logic [WORD_LENGTH-1:0] B,
  output logic                   busy,
  output logic                   done,
  output logic [WORD_LENGTH-1:0] out,
  output logic                   ovf
);
  localparam int M = WORD_LENGTH - 1;
  localparam int AW = 2 * M;
  localparam int CW = $clog2(M);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic [M-1:0] mag_a, mag_b, mag;
  logic sgn, sat;
  logic [AW-1:0] acc, scaled;
  logic [CW-1:0] cnt;
  always_comb begin
    scaled = acc >> FRAC_BITS;
    sat = |scaled[AW-1:M];
    mag = sat ? '1 : scaled[M-1:0];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      out <= '0;
      ovf <= 1'b0;
      mag_a <= '0;
      mag_b <= '0;
      sgn <= 1'b0;
      acc <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= start;
          if (start) begin
            mag_a <= A[M-1:0];
            mag_b <= B[M-1:0];
            sgn <= A[M] ^ B[M];
            acc <= '0;
            cnt <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          if (mag_b[cnt]) acc <= acc + (AW'(mag_a) << cnt);
          cnt <= cnt + 1'b1;
          if (cnt == CW'(M - 1)) state <= DONE;
        end
        DONE: begin
          out <= {sgn & |mag, mag};
          ovf <= sat;
          done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
